// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: owns the PC, issues one outstanding imem request
// at a time, holds each fetched word for decode, and handles redirects and halt.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [31:0]        fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD
  } state_e;

  state_e               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    pending_q;
  logic                 kill_q;
  logic [INSTR_W-1:0]   instr_q;
  logic [ADDR_W-1:0]    pc_q;
  logic [31:0]          count_q;
  state_e               resume_d;

  // Where to go once nothing is outstanding or held: halt only blocks a new request.
  always_comb begin
    resume_d = halt ? ST_IDLE : ST_REQ;
  end

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below sees the pre-edge values of the registers it reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= RESET_PC;
      pending_q <= '0;
      kill_q    <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      count_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect_valid) addr_q <= redirect_pc;
          state_q <= resume_d;
        end
        ST_REQ: begin
          if (imem_ack) begin
            if (redirect_valid) begin
              addr_q  <= redirect_pc;
              kill_q  <= 1'b0;
              state_q <= resume_d;
            end else if (kill_q) begin
              // Stale response for a fetch that was redirected away while waiting.
              addr_q  <= pending_q;
              kill_q  <= 1'b0;
              state_q <= resume_d;
            end else begin
              instr_q <= imem_rdata;
              pc_q    <= addr_q;
              addr_q  <= addr_q + PC_STEP;
              state_q <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            kill_q    <= 1'b1;
            pending_q <= redirect_pc;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            addr_q  <= redirect_pc;
            state_q <= resume_d;
          end else if (if_ready) begin
            count_q <= count_q + 32'd1;
            state_q <= resume_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = addr_q;
  assign if_valid    = (state_q == ST_HOLD);
  assign if_instr    = instr_q;
  assign if_pc       = pc_q;
  assign fetch_count = count_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Front-end controller for the pipelined processor's instruction fetch stage. It owns the program counter and sequences single-outstanding requests to instruction memory over a req/ack handshake. It presents each fetched word to decode through a valid/ready interface. It redirects the PC on jump/branch requests from later stages, discarding any stale in-flight fetch, and stops issuing fetches while `halt` is asserted.

## Interface
Parameters:
- `ADDR_W`, 32, PC / instruction-memory word-address width
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 0, first fetch address after reset
- `PC_STEP`, 1, sequential increment (word-addressed memory)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low
- `halt`  in  1  when high, no new fetch request is started
- `redirect_valid`  in  1  jump/branch taken; one-cycle pulse sampled at the clock edge
- `redirect_pc`  in  ADDR_W  target address, valid with `redirect_valid`
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_W  fetch address
- `imem_ack`  in  1  memory response; completes the transaction at an edge where `imem_req && imem_ack`
- `imem_rdata`  in  INSTR_W  instruction data, valid with `imem_ack`
- `if_valid`  out  1  instruction held for decode
- `if_ready`  in  1  decode accepts at an edge where `if_valid && if_ready`
- `if_instr`  out  INSTR_W  held instruction
- `if_pc`  out  ADDR_W  address of `if_instr`
- `fetch_count`  out  32  count of instructions delivered to decode

## Operation
- States:
  - IDLE: no request, nothing held.
  - REQ: `imem_req=1`.
  - HOLD: `if_valid=1`, `imem_req=0`.
- Internal registers: `kill` flag and `pending_pc`.
- All outputs are decoded from registers. There is no combinational input-to-output path.
- IDLE:
  - `!halt` -> REQ.
  - `halt` -> stay in IDLE.
- REQ, no ack:
  - Stay in REQ.
  - `imem_addr` stays stable.
- REQ, ack, `kill=0`, no redirect:
  - Capture `if_instr<=imem_rdata` and `if_pc<=imem_addr`.
  - Update `imem_addr<=imem_addr+PC_STEP` (modulo 2^ADDR_W).
  - Go to HOLD.
- REQ, ack, `kill=1`:
  - Discard the data.
  - `imem_addr<=pending_pc`, clear `kill`.
  - Go to REQ if `!halt`, else IDLE.
- HOLD, no accept: stay in HOLD; `if_instr` and `if_pc` stay stable.
- HOLD, accept:
  - `fetch_count` += 1 (wraps).
  - Go to REQ if `!halt`, else IDLE.
- Redirect handling, by state at the sampling edge:
  - IDLE: `imem_addr<=redirect_pc`; go to REQ if `!halt`, else stay in IDLE.
  - HOLD: drop the held instruction, even if `if_ready` is high at the same edge; it is not counted. `imem_addr<=redirect_pc`; go to REQ if `!halt`, else IDLE.
  - REQ, ack at the same edge: discard the data. `imem_addr<=redirect_pc`; go to REQ if `!halt`, else IDLE.
  - REQ, no ack: `kill<=1`, `pending_pc<=redirect_pc`. The request and its address stay unchanged until the ack arrives.
  - REQ with `kill` already 1: `pending_pc` is overwritten (latest redirect wins).
- `halt` never aborts an outstanding request or a held instruction. It only blocks starting a new request.

## Timing
- While `reset` is low:
  - State is IDLE.
  - `imem_req=0`, `if_valid=0`, `kill=0`.
  - `imem_addr=RESET_PC`, `if_pc=0`, `if_instr=0`, `pending_pc=0`, `fetch_count=0`.
- Reset asserted mid-transaction: all state is cleared immediately. The response is ignored, and any ack arriving later while not in REQ is ignored.
- First request: `imem_req` rises one cycle after the first edge with `reset` high and `halt` low.
- Zero-wait memory (ack in the same cycle as req): the REQ -> HOLD -> REQ loop delivers one instruction every 2 cycles while `if_ready=1`.
- Each memory wait cycle adds one cycle of latency.
- `if_valid` rises on the edge after the completing ack.
- After a redirect, the next `imem_req` targets `redirect_pc`:
  - one cycle later if the redirect arrives in IDLE or HOLD, or with the ack;
  - one cycle after the stale ack otherwise.
- `imem_ack` outside REQ has no effect.

## Test plan
- Reset release, `halt=0`, zero-wait memory returning word = addr, `if_ready=1`: observe `imem_addr` 0,1,2,3; `if_pc`/`if_instr` 0,1,2,3 on every second cycle; `fetch_count`=4 after the fourth accept.
- Decode stall: `if_ready=0` for 5 cycles while in HOLD at `if_pc`=2 -> `if_valid` stays 1, `if_instr` is stable, no `imem_req`, and `fetch_count` is unchanged until the accept.
- Redirect during a 3-cycle memory wait on addr 4, `redirect_pc`=0x40 -> `imem_addr` stays 4 until ack; data for 4 never appears on `if_valid`; next request is 0x40, then `if_pc`=0x40.
- Two redirects (0x40, then 0x80) during one outstanding wait -> only 0x80 is fetched after the stale ack.
- Redirect to 0x10 coincident with `if_valid && if_ready` at `if_pc`=5 -> `fetch_count` is not incremented; next `if_pc`=0x10.
- `halt` raised while in REQ at addr 7 -> ack completes, instruction 7 is delivered, then IDLE with no `imem_req`. Releasing `halt` -> request to 8. Asserting `reset` low mid-wait -> all outputs return to reset values immediately.
